// File: rtl/pipe_delay_pkg.sv
// Shared defaults and helpers for the pipe_delay elastic delay line.
package pipe_delay_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;

  // Bits needed to hold an occupancy count of 0..depth
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_delay_if.sv
// Upstream/downstream valid-ready bundle plus occupancy for pipe_delay.
interface pipe_delay_if
  import pipe_delay_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
);

  localparam int unsigned CW = cnt_w(DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/pipe_stage.sv
// One valid+data register of the delay line: async reset, sync clear, load enable.
module pipe_stage #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclr_i,
  input  logic             load_i,
  input  logic             v_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             v_o,
  output logic [WIDTH-1:0] d_o
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  // Data only moves with a valid word; an emptied stage keeps its stale data
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (!sclr_i) begin
      v_d = 1'b0;
      d_d = RESET_VAL;
    end else if (load_i) begin
      v_d = v_i;
      if (v_i) d_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= 1'b0;
      d_q <= RESET_VAL;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v_o = v_q;
  assign d_o = d_q;

endmodule

// File: rtl/pipe_delay.sv
// Elastic DEPTH-stage register pipeline with collapsing bubbles and occupancy count.
module pipe_delay
  import pipe_delay_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter int unsigned      DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sclr,
  pipe_delay_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [DEPTH:0]   acc;
  logic             in_fire;
  logic             out_fire;
  logic             out_valid_c;
  logic [CW-1:0]    count_q, count_d;

  // Accept chain: a stage may load if it is empty or its successor is loading
  always_comb begin
    acc        = '0;
    acc[DEPTH] = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc[i] = ~v[i] | acc[i+1];
    end
  end

  assign out_valid_c  = v[DEPTH-1] & sclr;
  assign bus.in_ready = acc[0] & sclr & rst;
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign out_fire     = out_valid_c & bus.out_ready;

  for (genvar j = 0; j < DEPTH; j++) begin : g_stage
    if (j == 0) begin : g_head
      assign src_v[j] = in_fire;
      assign src_d[j] = bus.in_data;
    end else begin : g_body
      assign src_v[j] = v[j-1];
      assign src_d[j] = d[j-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .sclr_i (sclr),
      .load_i (acc[j]),
      .v_i    (src_v[j]),
      .d_i    (src_d[j]),
      .v_o    (v[j]),
      .d_o    (d[j])
    );
  end

  // Occupancy tracks popcount(v) via fire events
  always_comb begin
    count_d = count_q;
    if (!sclr) begin
      count_d = '0;
    end else if (in_fire && !out_fire) begin
      count_d = count_q + CW'(1);
    end else if (out_fire && !in_fire) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = d[DEPTH-1];
  assign bus.count     = count_q;

endmodule

// File: tb/tb_pipe_delay.sv
// Directed bench for pipe_delay: 8x4 instance with RESET_VAL A5 plus a 1x1 corner instance.
module tb_pipe_delay;

  logic clk = 1'b0;
  logic rst;
  logic sclr;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pipe_delay_if #(.WIDTH(8), .DEPTH(4)) bus_a ();
  pipe_delay_if #(.WIDTH(1), .DEPTH(1)) bus_b ();

  pipe_delay #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) u_a (
    .clk(clk), .rst(rst), .sclr(sclr), .bus(bus_a)
  );

  pipe_delay #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u_b (
    .clk(clk), .rst(rst), .sclr(sclr), .bus(bus_b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; sclr = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = 8'h00; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = 1'b0;  bus_b.out_ready = 1'b0;
    #12;
    tests++; if (bus_a.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b exp 0", bus_a.out_valid); end
    tests++; if (bus_a.out_data !== 8'hA5) begin fails++; $display("FAIL rst_out_data got %0h exp a5", bus_a.out_data); end
    tests++; if (bus_a.count !== 3'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", bus_a.count); end
    tests++; if (bus_a.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %b exp 0", bus_a.in_ready); end
    @(negedge clk); rst = 1'b1;
    cyc();
    tests++; if (bus_a.in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_in_ready got %b exp 1", bus_a.in_ready); end
    // three words in flight, then an asynchronous reset between edges
    for (int i = 0; i < 3; i++) begin
      bus_a.in_valid = 1'b1; bus_a.in_data = 8'(i + 1);
      cyc();
    end
    tests++; if (bus_a.count !== 3'd3) begin fails++; $display("FAIL rst_pre_count got %0d exp 3", bus_a.count); end
    #2; rst = 1'b0; #1;
    tests++; if (bus_a.out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_out_valid got %b exp 0", bus_a.out_valid); end
    tests++; if (bus_a.out_data !== 8'hA5) begin fails++; $display("FAIL rst_mid_out_data got %0h exp a5", bus_a.out_data); end
    tests++; if (bus_a.count !== 3'd0) begin fails++; $display("FAIL rst_mid_count got %0d exp 0", bus_a.count); end
    tests++; if (bus_a.in_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_in_ready got %b exp 0", bus_a.in_ready); end
    #1; rst = 1'b1; bus_a.in_valid = 1'b0;
    cyc();
    tests++; if (bus_a.in_ready !== 1'b1) begin fails++; $display("FAIL rst_after_in_ready got %b exp 1", bus_a.in_ready); end
    tests++; if (bus_a.count !== 3'd0) begin fails++; $display("FAIL rst_after_count got %0d exp 0", bus_a.count); end
  endtask

  task automatic test_throughput();
    int  acc_n = 0;
    int  del_n = 0;
    bit  prev_v = 1'b0;
    bit  exp_v;
    bus_a.out_ready = 1'b1;
    for (int e = 0; e < 20; e++) begin
      bus_a.in_valid = (e < 16);
      bus_a.in_data  = 8'(e + 1);
      #1;
      if (e < 16) begin
        tests++; if (bus_a.in_ready !== 1'b1) begin fails++; $display("FAIL tput_in_ready e=%0d got %b exp 1", e, bus_a.in_ready); end
      end
      cyc();
      if (e < 16) acc_n++;
      if (prev_v) del_n++;
      exp_v  = (e >= 3) && (e < 19);
      prev_v = exp_v;
      tests++; if (bus_a.out_valid !== exp_v) begin fails++; $display("FAIL tput_out_valid e=%0d got %b exp %b", e, bus_a.out_valid, exp_v); end
      if (exp_v) begin
        tests++; if (bus_a.out_data !== 8'(e - 2)) begin fails++; $display("FAIL tput_out_data e=%0d got %0h exp %0h", e, bus_a.out_data, 8'(e - 2)); end
      end
      tests++; if (bus_a.count !== 3'(acc_n - del_n)) begin fails++; $display("FAIL tput_count e=%0d got %0d exp %0d", e, bus_a.count, acc_n - del_n); end
    end
    bus_a.in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] w [4]   = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] dr [3]  = '{8'h44, 8'h55, 8'h66};
    bus_a.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus_a.in_valid = 1'b1; bus_a.in_data = w[c];
      #1;
      tests++; if (bus_a.in_ready !== 1'b1) begin fails++; $display("FAIL bp_fill_in_ready c=%0d got %b exp 1", c, bus_a.in_ready); end
      cyc();
    end
    bus_a.in_data = 8'h55;
    for (int h = 0; h < 2; h++) begin
      #1;
      tests++; if (bus_a.in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_in_ready h=%0d got %b exp 0", h, bus_a.in_ready); end
      tests++; if (bus_a.count !== 3'd4) begin fails++; $display("FAIL bp_full_count h=%0d got %0d exp 4", h, bus_a.count); end
      tests++; if (bus_a.out_valid !== 1'b1) begin fails++; $display("FAIL bp_full_out_valid h=%0d got %b exp 1", h, bus_a.out_valid); end
      tests++; if (bus_a.out_data !== 8'h11) begin fails++; $display("FAIL bp_hold_out_data h=%0d got %0h exp 11", h, bus_a.out_data); end
      cyc();
    end
    bus_a.out_ready = 1'b1;
    #1;
    tests++; if (bus_a.in_ready !== 1'b1) begin fails++; $display("FAIL bp_full_drain_in_ready got %b exp 1", bus_a.in_ready); end
    cyc();
    tests++; if (bus_a.count !== 3'd4) begin fails++; $display("FAIL bp_swap_count got %0d exp 4", bus_a.count); end
    tests++; if (bus_a.out_data !== 8'h22) begin fails++; $display("FAIL bp_swap_out_data got %0h exp 22", bus_a.out_data); end
    bus_a.in_data = 8'h66;
    cyc();
    tests++; if (bus_a.count !== 3'd4) begin fails++; $display("FAIL bp_swap2_count got %0d exp 4", bus_a.count); end
    tests++; if (bus_a.out_data !== 8'h33) begin fails++; $display("FAIL bp_swap2_out_data got %0h exp 33", bus_a.out_data); end
    bus_a.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      tests++; if (bus_a.out_data !== dr[k]) begin fails++; $display("FAIL bp_drain_data k=%0d got %0h exp %0h", k, bus_a.out_data, dr[k]); end
      tests++; if (bus_a.count !== 3'(3 - k)) begin fails++; $display("FAIL bp_drain_count k=%0d got %0d exp %0d", k, bus_a.count, 3 - k); end
    end
    cyc();
    tests++; if (bus_a.out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty_out_valid got %b exp 0", bus_a.out_valid); end
  endtask

  task automatic test_bubble();
    logic [7:0] w [3] = '{8'hC1, 8'hC2, 8'hC3};
    bus_a.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus_a.in_valid = 1'b1; bus_a.in_data = w[k];
      cyc();
      bus_a.in_valid = 1'b0;
      cyc();
      cyc();
    end
    cyc();
    tests++; if (bus_a.count !== 3'd3) begin fails++; $display("FAIL bub_count got %0d exp 3", bus_a.count); end
    tests++; if (bus_a.in_ready !== 1'b1) begin fails++; $display("FAIL bub_in_ready got %b exp 1", bus_a.in_ready); end
    bus_a.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (bus_a.out_valid !== 1'b1) begin fails++; $display("FAIL bub_out_valid k=%0d got %b exp 1", k, bus_a.out_valid); end
      tests++; if (bus_a.out_data !== w[k]) begin fails++; $display("FAIL bub_out_data k=%0d got %0h exp %0h", k, bus_a.out_data, w[k]); end
      cyc();
    end
    tests++; if (bus_a.out_valid !== 1'b0) begin fails++; $display("FAIL bub_end_out_valid got %b exp 0", bus_a.out_valid); end
    tests++; if (bus_a.count !== 3'd0) begin fails++; $display("FAIL bub_end_count got %0d exp 0", bus_a.count); end
  endtask

  task automatic test_sclr();
    bus_a.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus_a.in_valid = 1'b1; bus_a.in_data = 8'(8'hD1 + k);
      cyc();
    end
    bus_a.in_valid = 1'b0;
    cyc();
    tests++; if (bus_a.count !== 3'd3) begin fails++; $display("FAIL clr_pre_count got %0d exp 3", bus_a.count); end
    tests++; if (bus_a.out_valid !== 1'b1) begin fails++; $display("FAIL clr_pre_out_valid got %b exp 1", bus_a.out_valid); end
    sclr = 1'b0; bus_a.in_valid = 1'b1; bus_a.in_data = 8'hD4; bus_a.out_ready = 1'b1;
    #1;
    tests++; if (bus_a.in_ready !== 1'b0) begin fails++; $display("FAIL clr_in_ready got %b exp 0", bus_a.in_ready); end
    tests++; if (bus_a.out_valid !== 1'b0) begin fails++; $display("FAIL clr_out_valid got %b exp 0", bus_a.out_valid); end
    cyc();
    sclr = 1'b1; bus_a.in_valid = 1'b0;
    #1;
    tests++; if (bus_a.count !== 3'd0) begin fails++; $display("FAIL clr_count got %0d exp 0", bus_a.count); end
    tests++; if (bus_a.out_valid !== 1'b0) begin fails++; $display("FAIL clr_post_out_valid got %b exp 0", bus_a.out_valid); end
    tests++; if (bus_a.out_data !== 8'hA5) begin fails++; $display("FAIL clr_out_data got %0h exp a5", bus_a.out_data); end
    tests++; if (bus_a.in_ready !== 1'b1) begin fails++; $display("FAIL clr_post_in_ready got %b exp 1", bus_a.in_ready); end
    cyc();
  endtask

  task automatic test_depth1();
    logic q [$];
    bit   exp_ir;
    for (int n = 0; n < 1000; n++) begin
      tests++; if (int'(bus_b.count) != q.size()) begin fails++; $display("FAIL d1_count n=%0d got %0d exp %0d", n, bus_b.count, q.size()); end
      bus_b.in_valid  = 1'($urandom_range(0, 1));
      bus_b.in_data   = 1'($urandom_range(0, 1));
      bus_b.out_ready = 1'($urandom_range(0, 1));
      #1;
      exp_ir = (q.size() == 0) || bus_b.out_ready;
      tests++; if (bus_b.in_ready !== exp_ir) begin fails++; $display("FAIL d1_in_ready n=%0d got %b exp %b", n, bus_b.in_ready, exp_ir); end
      tests++; if (bus_b.out_valid !== (q.size() != 0)) begin fails++; $display("FAIL d1_out_valid n=%0d got %b exp %b", n, bus_b.out_valid, q.size() != 0); end
      if (bus_b.out_valid && bus_b.out_ready) begin
        if (q.size() == 0) begin
          tests++; fails++; $display("FAIL d1_dup n=%0d got out_fire exp none", n);
        end else begin
          tests++; if (bus_b.out_data !== q[0]) begin fails++; $display("FAIL d1_data n=%0d got %b exp %b", n, bus_b.out_data, q[0]); end
          void'(q.pop_front());
        end
      end
      if (bus_b.in_valid && bus_b.in_ready) q.push_back(bus_b.in_data);
      cyc();
    end
    bus_b.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_throughput();
    test_backpressure();
    test_bubble();
    test_sclr();
    test_depth1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
